time_capture_ctrl: RTL and testbench

Trigger-based capture sequencer for the time-domain display buffer. It sits between the PDM decoder's 48 kHz sample stream and port A of the time-buffer block RAM. It drives enaTime/weaTime/addraTime/dinaTime so each displayed frame holds a stable, trigger-aligned waveform instead of a free-running write. It supports auto, normal and single-shot trigger modes, sample decimation, freeze, and a tear-free holdoff synchronized to the video frame.

---
 rtl/time_capture_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_time_capture_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_capture_ctrl.sv
// -----------------------------------------------------------------------------
// time_capture_ctrl
//
// Trigger-based capture sequencer for the time-domain display buffer. It takes
// the 48 kHz sample stream and writes trigger-aligned frames of DEPTH samples
// into port A of the time-buffer block RAM. Supports auto, normal and
// single-shot triggering, power-of-two decimation, freeze, and a holdoff that
// releases only on a video frame start so the display never shows a torn frame.
//
// Ports:
//   ck100MHz    in   system clock, rising edge
//   rstN        in   asynchronous active-low reset
//   sampleStb   in   one-cycle pulse, sampleData valid
//   sampleData  in   signed 8-bit time sample
//   trigLevel   in   signed 8-bit trigger threshold
//   trigMode    in   00 auto, 01 normal, 10 single, 11 auto
//   decim       in   keep one sample in every 2^decim strobes
//   freeze      in   level, inhibits starting a new capture
//   armStb      in   one-cycle pulse, re-arms after a single-shot capture
//   frameStb    in   one-cycle pulse at video frame start (ck100MHz domain)
//   enaTime     out  buffer port A enable
//   weaTime     out  buffer port A write enable
//   addraTime   out  buffer write address
//   dinaTime    out  buffer write data
//   busy        out  waiting for a trigger or capturing
//   trigForced  out  last capture was started by the auto timeout
// -----------------------------------------------------------------------------
module time_capture_ctrl #(
   parameter int DEPTH        = 640,
   parameter int AUTO_TIMEOUT = 4800,
   parameter int ADDR_W       = 10
) (
   input  logic              ck100MHz,
   input  logic              rstN,
   input  logic              sampleStb,
   input  logic [7:0]        sampleData,
   input  logic [7:0]        trigLevel,
   input  logic [1:0]        trigMode,
   input  logic [2:0]        decim,
   input  logic              freeze,
   input  logic              armStb,
   input  logic              frameStb,
   output logic              enaTime,
   output logic              weaTime,
   output logic [ADDR_W-1:0] addraTime,
   output logic [7:0]        dinaTime,
   output logic              busy,
   output logic              trigForced
);

   localparam int TO_W = (AUTO_TIMEOUT > 2) ? $clog2(AUTO_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TRIG,
      S_CAPTURE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state;
   logic [6:0]        stb_cnt;      // counts every strobe, cleared on WAIT_TRIG entry
   logic [TO_W-1:0]   to_cnt;       // accepted samples seen while waiting (auto mode)
   logic [ADDR_W-1:0] wr_cnt;       // next capture address
   logic [7:0]        prev_sample;  // last accepted sample, for edge detection
   logic [1:0]        mode_q;       // trigger mode latched at WAIT_TRIG entry
   logic [2:0]        decim_q;      // decimation latched at WAIT_TRIG entry

   logic [6:0] dec_mask;
   logic       accept;
   logic       crossing;
   logic       auto_mode;
   logic       single_mode;
   logic       timeout;
   logic       enter_wait;

   // decim=7 wraps the shift to zero, so the mask becomes all ones (1 in 128).
   assign dec_mask    = (7'd1 << decim_q) - 7'd1;
   assign accept      = sampleStb && ((stb_cnt & dec_mask) == 7'd0);
   assign crossing    = accept
                        && ($signed(prev_sample) <  $signed(trigLevel))
                        && ($signed(sampleData)  >= $signed(trigLevel));
   assign single_mode = (mode_q == 2'b10);
   assign auto_mode   = (mode_q != 2'b01) && !single_mode;
   assign timeout     = accept && auto_mode && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

   // frameStb wins over a coincident sample in HOLD: the sample never writes,
   // and because the trigger check only runs in WAIT_TRIG, a sample arriving on
   // the entry cycle cannot trigger either.
   assign enter_wait  = !freeze && ((state == S_IDLE)
                        || (state == S_HOLD && frameStb && !single_mode));

   // NOTE: all state uses non-blocking assignments and the async reset branch
   // clears every register, so a reset mid-capture drops the outputs at once
   // while the RAM contents are simply left alone.
   always_ff @(posedge ck100MHz or negedge rstN) begin
      if (!rstN) begin
         state       <= S_IDLE;
         stb_cnt     <= '0;
         to_cnt      <= '0;
         wr_cnt      <= '0;
         prev_sample <= '0;
         mode_q      <= '0;
         decim_q     <= '0;
         enaTime     <= 1'b0;
         weaTime     <= 1'b0;
         addraTime   <= '0;
         dinaTime    <= '0;
         busy        <= 1'b0;
         trigForced  <= 1'b0;
      end else begin
         // NOTE: the write strobes default low every cycle so a write is a
         // single-cycle pulse; address and data keep their last values.
         enaTime <= 1'b0;
         weaTime <= 1'b0;

         // busy follows the state one cycle late.
         busy <= (state == S_WAIT_TRIG) || (state == S_CAPTURE);

         if (accept) begin
            prev_sample <= sampleData;
         end

         if (enter_wait) begin
            stb_cnt <= '0;
            to_cnt  <= '0;
            mode_q  <= trigMode;
            decim_q <= decim;
         end else if (sampleStb) begin
            stb_cnt <= stb_cnt + 7'd1;
         end

         unique case (state)
            S_IDLE: begin
               if (!freeze) begin
                  state <= S_WAIT_TRIG;
               end
            end

            S_WAIT_TRIG: begin
               if (crossing || timeout) begin
                  enaTime    <= 1'b1;
                  weaTime    <= 1'b1;
                  addraTime  <= '0;
                  dinaTime   <= sampleData;
                  wr_cnt     <= ADDR_W'(1);
                  trigForced <= !crossing;
                  state      <= (DEPTH == 1) ? S_HOLD : S_CAPTURE;
               end else if (accept && auto_mode) begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            S_CAPTURE: begin
               if (accept) begin
                  enaTime   <= 1'b1;
                  weaTime   <= 1'b1;
                  addraTime <= wr_cnt;
                  dinaTime  <= sampleData;
                  if (wr_cnt == ADDR_W'(DEPTH - 1)) begin
                     state <= S_HOLD;
                  end else begin
                     wr_cnt <= wr_cnt + ADDR_W'(1);
                  end
               end
            end

            S_HOLD: begin
               if (frameStb) begin
                  if (single_mode) begin
                     state <= S_DONE;
                  end else if (freeze) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_WAIT_TRIG;
                  end
               end
            end

            S_DONE: begin
               if (armStb) begin
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_time_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_capture_ctrl
//
// Directed bench for time_capture_ctrl with DEPTH=640, AUTO_TIMEOUT=4800.
// A negedge monitor tallies buffer writes and address-sequence anomalies; the
// main sequence compares those tallies and the outputs against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_time_capture_ctrl;

   localparam int DEPTH        = 640;
   localparam int AUTO_TIMEOUT = 4800;
   localparam int ADDR_W       = 10;

   logic              clk;
   logic              rst_n;
   logic              sampleStb;
   logic [7:0]        sampleData;
   logic [7:0]        trigLevel;
   logic [1:0]        trigMode;
   logic [2:0]        decim;
   logic              freeze;
   logic              armStb;
   logic              frameStb;
   logic              enaTime;
   logic              weaTime;
   logic [ADDR_W-1:0] addraTime;
   logic [7:0]        dinaTime;
   logic              busy;
   logic              trigForced;

   time_capture_ctrl #(
      .DEPTH       (DEPTH),
      .AUTO_TIMEOUT(AUTO_TIMEOUT),
      .ADDR_W      (ADDR_W)
   ) dut (
      .ck100MHz  (clk),
      .rstN      (rst_n),
      .sampleStb (sampleStb),
      .sampleData(sampleData),
      .trigLevel (trigLevel),
      .trigMode  (trigMode),
      .decim     (decim),
      .freeze    (freeze),
      .armStb    (armStb),
      .frameStb  (frameStb),
      .enaTime   (enaTime),
      .weaTime   (weaTime),
      .addraTime (addraTime),
      .dinaTime  (dinaTime),
      .busy      (busy),
      .trigForced(trigForced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- write monitor ----------------
   int         wr_total   = 0;
   int         seq_err    = 0;
   int         range_err  = 0;
   int         pulse_err  = 0;
   int         ena_err    = 0;
   int         last_addr  = 0;
   logic [7:0] last_data  = 8'h00;
   logic [7:0] first_data = 8'h00;
   logic       prev_we    = 1'b0;

   always @(negedge clk) begin
      if (weaTime !== enaTime) ena_err++;
      if (weaTime === 1'b1) begin
         if (prev_we) pulse_err++;
         if (int'(addraTime) >= DEPTH) range_err++;
         if (addraTime == '0) first_data = dinaTime;
         else if (int'(addraTime) != last_addr + 1) seq_err++;
         last_addr = int'(addraTime);
         last_data = dinaTime;
         wr_total++;
      end
      prev_we = (weaTime === 1'b1);
   end

   // ---------------- helpers ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      sampleData = d;
      sampleStb  = 1'b1;
      tick();
      sampleStb  = 1'b0;
      tick();
   endtask

   task automatic pulse_frame();
      frameStb = 1'b1;
      tick();
      frameStb = 1'b0;
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int         base;
      logic [7:0] r;

      rst_n      = 1'b0;
      sampleStb  = 1'b0;
      sampleData = 8'h00;
      trigLevel  = 8'h00;
      trigMode   = 2'b01;
      decim      = 3'd0;
      freeze     = 1'b1;
      armStb     = 1'b0;
      frameStb   = 1'b0;

      // ---- reset state ----
      tick(); tick();
      check("rst_ena",   32'(enaTime),    32'd0);
      check("rst_wea",   32'(weaTime),    32'd0);
      check("rst_addr",  32'(addraTime),  32'd0);
      check("rst_din",   32'(dinaTime),   32'd0);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_force", 32'(trigForced), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) tick();
      check("freeze_idle_busy", 32'(busy), 32'd0);

      // ---- normal mode, ramp -5..+5, level 0 ----
      freeze = 1'b0;
      tick();
      check("busy_lag1", 32'(busy), 32'd0);
      tick();
      check("busy_lag2", 32'(busy), 32'd1);
      base = wr_total;
      r = 8'hFB;                                // -5
      repeat (5) begin
         send(r);
         r = r + 8'd1;
      end
      check("ramp_pre_trig_writes", 32'(wr_total - base), 32'd0);
      sampleData = 8'h00;                       // crossing sample
      sampleStb  = 1'b1;
      tick();
      check("trig_we",   32'(weaTime),   32'd1);
      check("trig_addr", 32'(addraTime), 32'd0);
      check("trig_din",  32'(dinaTime),  32'd0);
      sampleStb = 1'b0;
      tick();
      check("trig_we_pulse", 32'(weaTime), 32'd0);
      r = 8'h01;
      repeat (DEPTH - 1) begin
         send(r);
         r = (r == 8'h05) ? 8'hFB : r + 8'd1;
      end
      check("ramp_writes",     32'(wr_total - base), 32'd640);
      check("ramp_last_addr",  32'(last_addr),       32'd639);
      check("ramp_last_data",  32'(last_data),       32'h01);
      check("ramp_busy_fall",  32'(busy),            32'd0);
      repeat (20) send(8'h03);
      check("hold_no_writes",  32'(wr_total - base), 32'd640);
      check("hold_addr_kept",  32'(addraTime),       32'd639);
      check("hold_data_kept",  32'(dinaTime),        32'h01);

      // ---- frameStb and sampleStb together in HOLD ----
      base       = wr_total;
      sampleData = 8'd77;
      sampleStb  = 1'b1;
      frameStb   = 1'b1;
      tick();
      sampleStb  = 1'b0;
      frameStb   = 1'b0;
      check("simul_no_write", 32'(weaTime), 32'd0);
      tick();
      check("simul_busy", 32'(busy), 32'd1);

      // ---- normal mode never times out: flat 10, level 20 ----
      trigLevel = 8'd20;
      repeat (AUTO_TIMEOUT + 10) send(8'd10);
      check("normal_flat_writes", 32'(wr_total - base), 32'd0);
      check("normal_flat_force",  32'(trigForced),      32'd0);
      check("normal_flat_busy",   32'(busy),            32'd1);

      // ---- real trigger, freeze raised at wrCnt=100 ----
      send(8'hF6);                              // -10
      send(8'd30);                              // crossing
      repeat (99) send(8'd7);
      freeze = 1'b1;
      repeat (DEPTH - 100) send(8'd7);
      check("freeze_writes",     32'(wr_total - base), 32'd640);
      check("freeze_first_data", 32'(first_data),      32'h1E);
      check("freeze_last_addr",  32'(last_addr),       32'd639);
      pulse_frame();
      repeat (3) begin
         send(8'hF6);
         send(8'd30);
      end
      check("freeze_parked_writes", 32'(wr_total - base), 32'd640);
      check("freeze_parked_busy",   32'(busy),            32'd0);

      // ---- auto mode forced trigger after 4800 accepted samples ----
      trigMode = 2'b00;
      freeze   = 1'b0;
      tick();
      base = wr_total;
      repeat (AUTO_TIMEOUT - 1) send(8'd10);
      check("auto_pre_timeout_writes", 32'(wr_total - base), 32'd0);
      check("auto_pre_timeout_force",  32'(trigForced),      32'd0);
      sampleData = 8'd10;
      sampleStb  = 1'b1;
      tick();
      check("auto_forced_we",    32'(weaTime),    32'd1);
      check("auto_forced_addr",  32'(addraTime),  32'd0);
      check("auto_forced_din",   32'(dinaTime),   32'h0A);
      check("auto_forced_flag",  32'(trigForced), 32'd1);
      sampleStb = 1'b0;
      tick();
      repeat (DEPTH - 1) send(8'd10);
      check("auto_writes",    32'(wr_total - base), 32'd640);
      check("auto_last_addr", 32'(last_addr),       32'd639);
      freeze = 1'b1;
      pulse_frame();

      // ---- decimation 2 with a continuous strobe train ----
      trigMode  = 2'b01;
      trigLevel = 8'h00;
      decim     = 3'd2;
      freeze    = 1'b0;
      tick();
      base = wr_total;
      for (int i = 0; i < 2560; i++) begin
         sampleStb  = 1'b1;
         sampleData = (i == 0) ? 8'hFF : (((i % 4) == 0) ? 8'(i / 4) : 8'hEE);
         tick();
      end
      sampleStb = 1'b0;
      tick(); tick();
      check("decim_writes_639", 32'(wr_total - base), 32'd639);
      sampleStb  = 1'b1;
      sampleData = 8'h80;
      tick();
      sampleStb  = 1'b0;
      tick(); tick();
      check("decim_writes_640", 32'(wr_total - base), 32'd640);
      check("decim_first_data", 32'(first_data),      32'h01);
      check("decim_last_data",  32'(last_data),       32'h80);
      check("decim_real_force", 32'(trigForced),      32'd0);
      sampleData = 8'hEE;
      sampleStb  = 1'b1;
      repeat (40) tick();
      sampleStb = 1'b0;
      tick();
      check("decim_hold_writes", 32'(wr_total - base), 32'd640);
      freeze = 1'b1;
      pulse_frame();
      decim = 3'd0;

      // ---- single shot, DONE, re-arm ----
      trigMode = 2'b10;
      freeze   = 1'b0;
      tick();
      base = wr_total;
      send(8'hFF);
      send(8'd5);
      repeat (DEPTH - 1) send(8'd3);
      check("single_writes",     32'(wr_total - base), 32'd640);
      check("single_first_data", 32'(first_data),      32'h05);
      pulse_frame();
      repeat (3) begin
         send(8'hFF);
         send(8'd5);
      end
      check("done_no_writes", 32'(wr_total - base), 32'd640);
      check("done_busy",      32'(busy),            32'd0);
      armStb = 1'b1;
      tick();
      armStb = 1'b0;
      tick(); tick();
      send(8'hFF);
      send(8'd5);
      repeat (299) send(8'd9);
      check("rearm_writes",    32'(wr_total - base), 32'd940);
      check("rearm_last_addr", 32'(addraTime),       32'd299);
      check("rearm_busy",      32'(busy),            32'd1);

      // ---- asynchronous reset mid-capture ----
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ena",   32'(enaTime),    32'd0);
      check("arst_wea",   32'(weaTime),    32'd0);
      check("arst_addr",  32'(addraTime),  32'd0);
      check("arst_din",   32'(dinaTime),   32'd0);
      check("arst_busy",  32'(busy),       32'd0);
      check("arst_force", 32'(trigForced), 32'd0);
      tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("arst_rel_busy1", 32'(busy), 32'd0);
      tick();
      check("arst_rel_busy2", 32'(busy), 32'd1);

      // ---- global write-stream invariants ----
      check("seq_errors",   32'(seq_err),   32'd0);
      check("range_errors", 32'(range_err), 32'd0);
      check("pulse_errors", 32'(pulse_err), 32'd0);
      check("ena_errors",   32'(ena_err),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
